// File: rtl/spi_master.sv
// SPI master: valid/ready word stream in, framed SPI out, all four CPOL/CPHA modes.
// Optional SPI_MASTER_LSB_FIRST_EN adds lsb_first_i for LSB-first shifting.
module spi_master #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned CS_COUNT   = 1,
  parameter int unsigned CLK_DIV    = 4,
  localparam int unsigned SEL_W     = (CS_COUNT > 1) ? $clog2(CS_COUNT) : 1
) (
  input  logic                  clk_sys_i,
  input  logic                  reset_ni,
  input  logic [SEL_W-1:0]      cs_sel_i,
  input  logic                  cpol_i,
  input  logic                  cpha_i,
  input  logic [DATA_WIDTH-1:0] tx_data_i,
  input  logic                  tx_last_i,
  input  logic                  tx_valid_i,
  output logic                  tx_ready_o,
  output logic [DATA_WIDTH-1:0] rx_data_o,
  output logic                  rx_valid_o,
  output logic                  busy_o,
  output logic                  spi_sck_o,
  output logic [CS_COUNT-1:0]   spi_cs_no,
  output logic                  spi_tx_o,
  input  logic                  spi_rx_i
`ifdef SPI_MASTER_LSB_FIRST_EN
  ,
  input  logic                  lsb_first_i
`endif
);

  localparam int unsigned DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned HALF_W = $clog2(2 * DATA_WIDTH);
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [HALF_W-1:0] HALF_LAST = HALF_W'(2 * DATA_WIDTH - 1);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, WAIT, TEARDOWN} state_t;

  state_t                state;
  logic [DIV_W-1:0]      div_cnt;
  logic [HALF_W-1:0]     half_cnt;
  logic                  cpol_q, cpha_q, lsb_q, last_q, pending;
  logic [DATA_WIDTH-1:0] tx_sr, rx_sr;

  logic                  lsb_in, accept, ld_cpha, ld_lsb;
  logic                  half_end, shift_evt, sample_evt, out_bit;
  logic [CS_COUNT-1:0]   cs_pat;
  logic [DATA_WIDTH-1:0] out_src, out_shifted, rx_shifted;

`ifdef SPI_MASTER_LSB_FIRST_EN
  assign lsb_in = lsb_first_i;
`else
  assign lsb_in = 1'b0;
`endif

  assign busy_o = (state != IDLE);
  assign accept = tx_valid_i & tx_ready_o;

  always_comb begin
    cs_pat = '1;
    for (int unsigned i = 0; i < CS_COUNT; i++) begin
      cs_pat[i] = (SEL_W'(i) != cs_sel_i);
    end
    ld_cpha     = (state == IDLE) ? cpha_i : cpha_q;
    ld_lsb      = (state == IDLE) ? lsb_in : lsb_q;
    // Outside SHIFT the next bit comes straight from the word being accepted.
    out_src     = (state == SHIFT) ? tx_sr : tx_data_i;
    out_bit     = ld_lsb ? out_src[0] : out_src[DATA_WIDTH-1];
    out_shifted = ld_lsb ? (out_src >> 1) : (out_src << 1);
    rx_shifted  = lsb_q ? {spi_rx_i, rx_sr[DATA_WIDTH-1:1]}
                        : {rx_sr[DATA_WIDTH-2:0], spi_rx_i};
    half_end    = (div_cnt == DIV_LAST);
    shift_evt   = half_cnt[0] ^ cpha_q;
    sample_evt  = ~shift_evt;
  end

  always_ff @(posedge clk_sys_i) begin
    if (!reset_ni) begin
      state      <= IDLE;
      div_cnt    <= '0;
      half_cnt   <= '0;
      cpol_q     <= 1'b0;
      cpha_q     <= 1'b0;
      lsb_q      <= 1'b0;
      last_q     <= 1'b0;
      pending    <= 1'b0;
      tx_sr      <= '0;
      rx_sr      <= '0;
      rx_data_o  <= '0;
      rx_valid_o <= 1'b0;
      tx_ready_o <= 1'b0;
      spi_sck_o  <= 1'b0;
      spi_tx_o   <= 1'b0;
      spi_cs_no  <= '1;
    end else begin
      rx_valid_o <= 1'b0;
      case (state)
        IDLE: begin
          cpol_q     <= cpol_i;
          spi_sck_o  <= cpol_i;
          tx_ready_o <= 1'b1;
          if (accept) begin
            cpha_q     <= cpha_i;
            lsb_q      <= lsb_in;
            spi_cs_no  <= cs_pat;
            last_q     <= tx_last_i;
            tx_ready_o <= 1'b0;
            div_cnt    <= '0;
            state      <= SETUP;
            if (ld_cpha) begin
              tx_sr <= tx_data_i;
            end else begin
              spi_tx_o <= out_bit;
              tx_sr    <= out_shifted;
            end
          end
        end
        SETUP: begin
          if (half_end) begin
            div_cnt  <= '0;
            half_cnt <= '0;
            state    <= SHIFT;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        SHIFT: begin
          if (!half_end) begin
            div_cnt <= div_cnt + 1'b1;
          end else begin
            div_cnt   <= '0;
            half_cnt  <= half_cnt + 1'b1;
            spi_sck_o <= ~spi_sck_o;
            if (shift_evt) begin
              spi_tx_o <= out_bit;
              tx_sr    <= out_shifted;
            end
            if (sample_evt) rx_sr <= rx_shifted;
            if (half_cnt == HALF_LAST) begin
              // Last half-period may itself be a sample edge (cpha=1).
              rx_data_o  <= sample_evt ? rx_shifted : rx_sr;
              rx_valid_o <= 1'b1;
              spi_sck_o  <= cpol_q;
              if (last_q) begin
                state <= TEARDOWN;
              end else begin
                state      <= WAIT;
                pending    <= 1'b0;
                tx_ready_o <= 1'b1;
              end
            end
          end
        end
        WAIT: begin
          if (!pending) begin
            if (accept) begin
              last_q     <= tx_last_i;
              pending    <= 1'b1;
              tx_ready_o <= 1'b0;
              div_cnt    <= '0;
              if (ld_cpha) begin
                tx_sr <= tx_data_i;
              end else begin
                spi_tx_o <= out_bit;
                tx_sr    <= out_shifted;
              end
            end
          end else if (half_end) begin
            div_cnt  <= '0;
            half_cnt <= '0;
            state    <= SHIFT;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        TEARDOWN: begin
          spi_cs_no <= '1;
          if (half_end) begin
            state      <= IDLE;
            tx_ready_o <= 1'b1;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/spi_master.md
Name: spi_master

Overview:
- Synthesizable, parametrised SPI controller. It is the hardware successor to the byte-level sim SPI driver.
- Accepts words over a valid/ready stream and runs frames of one or more words under a selected chip select.
- Supports all four CPOL/CPHA modes at a programmable SCK rate, and returns each received word on a one-cycle strobe.
- Sits between on-chip bus bridges and off-chip SPI peripherals (flash, SD, MCU link).

Parameters:
- DATA_WIDTH, 8: bits per word, ≥2.
- CS_COUNT, 1: number of chip-select outputs, ≥1.
- CLK_DIV, 4: clk_sys_i cycles per SCK half-period, ≥1.

Ports:
- clk_sys_i  in  1  system clock
- reset_ni  in  1  synchronous reset, active low
- cs_sel_i  in  $clog2(CS_COUNT) or 1 if CS_COUNT=1  CS index, latched at frame start
- cpol_i  in  1  SCK idle level, latched while IDLE
- cpha_i  in  1  0 = sample on leading edge, 1 = sample on trailing edge; latched at frame start
- tx_data_i  in  DATA_WIDTH  word to send
- tx_last_i  in  1  CS deasserts after this word
- tx_valid_i  in  1  word offered
- tx_ready_o  out  1  word accepted when valid&ready
- rx_data_o  out  DATA_WIDTH  received word
- rx_valid_o  out  1  one-cycle strobe, rx_data_o valid
- busy_o  out  1  frame in progress (CS asserted or in turnaround)
- spi_sck_o  out  1  SPI clock
- spi_cs_no  out  CS_COUNT  chip selects, active low
- spi_tx_o  out  1  MOSI
- spi_rx_i  in  1  MISO, assumed already synchronised

Behaviour:
- Reset (reset_ni=0 at posedge): state IDLE.
  - Outputs: spi_cs_no all 1; spi_sck_o=0; spi_tx_o=0; tx_ready_o=0; rx_valid_o=0; rx_data_o=0; busy_o=0.
  - Latched cpol=0, cpha=0.
  - Reset mid-frame aborts immediately; no rx_valid_o is issued.
- States: IDLE, SETUP, SHIFT, WAIT, TEARDOWN.
- tx_ready_o is 1 only in IDLE, and in WAIT with no word pending. Accept = tx_valid_i & tx_ready_o.
- IDLE:
  - cpol latched each cycle; spi_sck_o follows latched cpol.
  - On accept: latch cs_sel_i, cpha_i, tx_data_i and tx_last_i; go to SETUP.
- SETUP (CLK_DIV cycles):
  - Selected spi_cs_no bit = 0.
  - If cpha=0, MSB is on spi_tx_o from the first SETUP cycle.
  - If cs_sel ≥ CS_COUNT, all CS stay 1 but the transfer still runs.
- SHIFT:
  - 2·DATA_WIDTH half-periods of CLK_DIV cycles each. SCK toggles at the end of each half-period.
  - cpha=0: MISO sampled on leading edges; MOSI shifted on trailing edges.
  - cpha=1: MOSI updated on leading edges; MISO sampled on trailing edges.
  - MSB first. No SCK edge occurs outside SHIFT.
- Word end:
  - The cycle after the final half-period, rx_data_o is updated and rx_valid_o=1 for exactly one cycle.
  - SCK is back at the cpol level.
- After word end:
  - If tx_last=1: go to TEARDOWN.
  - Else: go to WAIT with CS held low.
- WAIT:
  - On accept, go to SHIFT for the next word after a CLK_DIV-cycle gap.
  - Back-to-back words therefore have a 1+CLK_DIV cycle gap. tx_valid_i held high gives continuous streaming.
  - cpha and cs_sel are not re-latched within a frame.
  - WAIT has no timeout; CS stays low indefinitely.
- TEARDOWN (CLK_DIV cycles):
  - Cycle 0: CS stays low (hold).
  - Remaining cycles: all CS=1 (minimum deselect).
  - Then go to IDLE.
- busy_o = (state != IDLE).
- Single word latency (accept → rx_valid_o), fixed: 1 + CLK_DIV + 2·DATA_WIDTH·CLK_DIV cycles.
- tx_data_i and tx_last_i are ignored except at accept.
- Changes to cpol_i outside IDLE are ignored.

Optional Feature:
- Macro: SPI_MASTER_LSB_FIRST_EN.
- Defined: adds input lsb_first_i (1 bit), latched at frame start alongside cpha. When 1, both shift directions run LSB first and rx_data_o is assembled so that bit 0 is the first bit received.
- Undefined: no port; always MSB first. Logic is identical otherwise.

Test Plan:
- Mode 0, DATA_WIDTH=8, CLK_DIV=2, single word 0xA5, last=1, MISO model returns 0x3C:
  - MOSI bits observed on SCK rising edges = 1,0,1,0,0,1,0,1.
  - rx_data_o=0x3C with a one-cycle rx_valid_o, exactly 35 cycles after accept.
  - CS low for 2+32+1 cycles.
- All four cpol/cpha combinations, word 0x81, looped MISO=MOSI:
  - SCK idles at cpol.
  - 16 SCK edges per word.
  - rx_data_o=0x81 each time.
- Three-word frame 0x01, 0x02, 0x03 (last on the third), tx_valid_i held high:
  - CS stays low across all three words.
  - rx_valid_o pulses 3 times.
  - Inter-word gap = 3 cycles.
  - CS rises only after the third word.
- CS_COUNT=4, cs_sel=2:
  - Only spi_cs_no[2] toggles.
  - With cs_sel=3 and CS_COUNT=3, no CS toggles but SCK still runs.
- Mid-frame reset after 5 SCK edges:
  - Next cycle: all CS=1, SCK=0, busy_o=0, no rx_valid_o.
  - A subsequent single-word 0x5A transfer completes correctly.
- With SPI_MASTER_LSB_FIRST_EN and lsb_first_i=1, send 0x01 with looped MISO:
  - First MOSI bit is 1.
  - rx_data_o=0x01.
